// File: rtl/apb3_bridge_mux_reg.sv
// Registered APB3 splitter: one target port fanned out to NUM_SLOTS completer slots,
// with per-slot enable mask, unmapped-access error and PREADY timeout.
module apb3_bridge_mux_reg #(
    parameter int          NUM_SLOTS   = 16,
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          MADDR_BITS  = 12,
    parameter logic [31:0] SLOT_EN     = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYC = 256
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    input  logic                        PWRITE,
    input  logic [ADDR_W-1:0]           PADDR,
    input  logic [DATA_W-1:0]           PWDATA,
    output logic [DATA_W-1:0]           PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERR,
    output logic [NUM_SLOTS-1:0]        PSELS,
    output logic                        PENABLES,
    output logic                        PWRITES,
    output logic [ADDR_W-1:0]           PADDRS,
    output logic [DATA_W-1:0]           PWDATAS,
    input  logic [NUM_SLOTS*DATA_W-1:0] PRDATAS,
    input  logic [NUM_SLOTS-1:0]        PREADYS,
    input  logic [NUM_SLOTS-1:0]        PSLVERRS,
    output logic                        TIMEOUT
);

    localparam int SEL_BITS = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [31:0] SLOT_MASK =
        (NUM_SLOTS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_SLOTS) - 32'd1);
    // Slots beyond NUM_SLOTS are folded into the enable mask as unmapped
    localparam logic [31:0] EN_MASK = SLOT_EN & SLOT_MASK;

    typedef enum logic [1:0] {
        IDLE,
        SETUP_S,
        ACCESS_S,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic                  write_q;
    logic [MADDR_BITS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [SEL_BITS-1:0]   sel_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;
    logic                  to_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [SEL_BITS-1:0] req_idx;
    logic                req_ok;
    logic                start;
    logic                slot_rdy;
    logic                slot_err;
    logic [DATA_W-1:0]   slot_rdata;
    logic                timed_out;
    logic                unused_bits;

    assign req_idx    = PADDR[MADDR_BITS+SEL_BITS-1:MADDR_BITS];
    assign req_ok     = EN_MASK[5'(req_idx)];
    assign start      = PSEL & ~PENABLE;
    assign slot_rdy   = PREADYS[sel_q];
    assign slot_err   = PSLVERRS[sel_q];
    assign slot_rdata = PRDATAS[int'(sel_q)*DATA_W +: DATA_W];
    assign timed_out  = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
    assign unused_bits = ^PADDR;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = req_ok ? SETUP_S : RESP;
            SETUP_S:  state_d = ACCESS_S;
            ACCESS_S: if (slot_rdy || timed_out) state_d = RESP;
            RESP:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        write_q <= PWRITE;
                        addr_q  <= PADDR[MADDR_BITS-1:0];
                        wdata_q <= PWDATA;
                        sel_q   <= req_idx;
                        err_q   <= ~req_ok;
                        rdata_q <= '0;
                        to_q    <= 1'b0;
                    end
                end
                SETUP_S: cnt_q <= '0;
                ACCESS_S: begin
                    // A ready on the last allowed cycle completes normally
                    if (slot_rdy) begin
                        rdata_q <= write_q ? '0 : slot_rdata;
                        err_q   <= slot_err;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        to_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: to_q <= 1'b0;
            endcase
        end
    end

    always_comb begin
        PSELS    = '0;
        PENABLES = 1'b0;
        PREADY   = 1'b0;
        PRDATA   = '0;
        PSLVERR  = 1'b0;
        TIMEOUT  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            PSELS[i] = ((state_q == SETUP_S) || (state_q == ACCESS_S))
                       && (sel_q == SEL_BITS'(i));
        end
        if (state_q == ACCESS_S) begin
            PENABLES = 1'b1;
        end
        if (state_q == RESP) begin
            PREADY  = 1'b1;
            PRDATA  = rdata_q;
            PSLVERR = err_q;
            TIMEOUT = to_q;
        end
    end

    assign PWRITES = write_q;
    assign PADDRS  = ADDR_W'(addr_q);
    assign PWDATAS = wdata_q;

endmodule
